shared_register_arbiter: RTL
============================

Name: shared_register_arbiter

Overview:
- Round-robin arbiter and load sequencer that shares one n-bit loadable register among N_REQ requesters.
- Collects requests, picks one winner per grant, and drives the register's load strobe and data input.
- Acknowledges the winner, then enforces a programmable idle gap before the next grant.
- Sits between requester blocks and the shared register's load/I inputs.

Parameters:
- n, 8, data width of the shared register.
- N_REQ, 4, number of requesters; 2..8.
- GAP, 2, idle cycles inserted after each load; 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants and does not abort one in progress.
- req  input  N_REQ  per-requester request level; held high until acked.
- data  input  N_REQ*n  flattened requester data; requester k uses bits [k*n +: n].
- load  output  1  load strobe to the shared register.
- I  output  n  data to the shared register.
- ack  output  N_REQ  one-hot grant acknowledge.
- owner  output  max(1,$clog2(N_REQ))  index of the last granted requester.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, reset_n=0) applies immediately, independent of clk:
  - state=IDLE, load=0, ack=0, I=0, busy=0.
  - Last-grant pointer and owner = N_REQ-1, so requester 0 has first priority.
  - Gap counter = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, LOAD, GAP.
- IDLE:
  - If en=1 and req!=0 at the rising edge, select winner w.
  - w is the first requester with req set, searching from (last+1) mod N_REQ upward with wrap.
  - At that edge register: load=1, I=data[w], ack=onehot(w), last=owner=w; go to LOAD.
  - Otherwise stay in IDLE with load=0, ack=0.
- LOAD: exactly one cycle with load=1 and ack=onehot(w).
  - The shared register captures I at the edge that ends LOAD.
  - At that edge: load=0, ack=0.
  - If GAP>0: go to GAP with counter=GAP-1.
  - If GAP=0: go to IDLE.
- GAP:
  - Decrement the counter each edge; go to IDLE when the counter = 0 at an edge.
  - Requests are ignored during GAP.
- Grant cadence: min spacing between load pulses = 2+GAP cycles; latency from req seen at edge to load high is 1 cycle.
- Requester contract:
  - Hold req and data stable from req assertion until the edge where it samples ack=1.
  - Drop req at that edge.
  - Because arbitration happens only in IDLE, which is at least one cycle after LOAD, a dropped req is never re-granted.
- Data is sampled only at the arbitration edge. Changes to data after that edge do not affect I.
- Requests withdrawn before the arbitration edge are not granted. No errors are flagged.
- Equal-priority ties cannot occur; round-robin order fully resolves simultaneous requests.
- en deasserted in LOAD or GAP: the sequence completes normally; the next grant waits for en=1 in IDLE.
- Reset mid-LOAD: load and ack drop immediately. The load is not guaranteed to take effect. After release, priority restarts at requester 0.
- owner holds its value between grants; it changes only at an arbitration edge or on reset.

Test Plan:
- Reset check: hold reset_n=0, toggle req/data -> load=0, ack=0, I=0, busy=0, owner=3 (N_REQ=4); check an async assert mid-cycle clears outputs before the next edge.
- Single request (GAP=2): req=4'b0010, data[1]=8'h5A -> next cycle load=1, I=8'h5A, ack=4'b0010, owner=1; busy high for 3 cycles; next load no earlier than 4 cycles after the first.
- Round-robin (GAP=0): all four req held, each dropped on its ack -> ack sequence 0001,0010,0100,1000; load pulses exactly 2 cycles apart; I matches each requester's data.
- Priority rotation: after owner=2, raise req[0] and req[3] together -> requester 3 granted first, requester 0 second.
- Reset mid-operation: assert reset_n=0 during LOAD for requester 2 -> load and ack drop immediately; after release with req=4'b0101 -> requester 0 granted first.
- Enable gating: en=0 with req=4'b1000 for 5 cycles -> no load or ack; raise en=1 -> load=1 and ack=4'b1000 one cycle after the first edge with en=1.

Source files
------------

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter and load sequencer sharing one n-bit loadable register
// among N_REQ requesters, with a fixed idle gap after every load.
module shared_register_arbiter #(
  parameter int n     = 8,
  parameter int N_REQ = 4,
  parameter int GAP   = 2,
  localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*n-1:0] data,
  output logic               load,
  output logic [n-1:0]       I,
  output logic [N_REQ-1:0]   ack,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               load_q, load_d;
  logic [n-1:0]       i_q, i_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [3:0]         gap_q, gap_d;
  logic               busy_q, busy_d;

  logic [OW-1:0]      win_s;
  logic               win_ok_s;
  logic [OW-1:0]      idx_s;
  logic [N_REQ-1:0]   onehot_s;
  logic [n-1:0]       sel_data_s;

  // Round-robin winner search starting just after the last grant (owner_q).
  // Scanning farthest-first lets the nearest requester overwrite the result.
  always_comb begin
    win_s    = owner_q;
    win_ok_s = 1'b0;
    idx_s    = '0;
    for (int s = N_REQ; s >= 1; s--) begin
      idx_s = OW'((int'(owner_q) + s) % N_REQ);
      if (req[idx_s]) begin
        win_s    = idx_s;
        win_ok_s = 1'b1;
      end else begin
        win_ok_s = win_ok_s;
      end
    end
  end

  // Decode the winner into its one-hot acknowledge and its data slice.
  always_comb begin
    onehot_s   = '0;
    sel_data_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_s == OW'(k)) begin
        onehot_s[k] = 1'b1;
        sel_data_s  = data[k*n +: n];
      end else begin
        onehot_s[k] = 1'b0;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/GAP sequence.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    ack_d   = '0;
    i_d     = i_q;
    owner_d = owner_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (en && win_ok_s) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
          ack_d   = onehot_s;
          i_d     = sel_data_s;
          owner_d = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = 4'(GAP - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; owner restarts at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      i_q     <= '0;
      ack_q   <= '0;
      owner_q <= OW'(N_REQ - 1);
      gap_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      i_q     <= i_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
    end
  end

  assign load  = load_q;
  assign I     = i_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
